relu_backprop_layer: RTL

Streaming backward pass for the rectifier layer of the CNN datapath. During the forward pass it records one mask bit per pre-activation pixel (1 if the value is strictly positive). During the backward pass it gates the incoming loss gradients with that mask, so gradients pass where the forward activation was positive and are zeroed elsewhere. It sits between the downstream layer's gradient output and the upstream convolution layer's gradient input, and owns the mask storage for one frame.

---
 rtl/relu_backprop_layer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/relu_backprop_layer.sv
// ReLU backward pass: records a positivity mask during the forward frame, then gates gradients with it.
// Optional build macro RELU_BP_LEAKY_EN: masked gradients become grad_in >>> LEAK_SHIFT instead of 0.
module relu_backprop_layer #(
  parameter int INPUT_SIZE     = 5,
  parameter int INPUT_CHANNELS = 3,
  parameter int PX_SIZE        = 8,
  parameter int LEAK_SHIFT     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fwd_valid,
  output logic               fwd_ready,
  input  logic [PX_SIZE-1:0] fwd_px,
  input  logic               grad_in_valid,
  output logic               grad_in_ready,
  input  logic [PX_SIZE-1:0] grad_in,
  output logic               grad_out_valid,
  input  logic               grad_out_ready,
  output logic [PX_SIZE-1:0] grad_out,
  output logic               mask_full,
  output logic               frame_done
);

  localparam int unsigned N     = INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS;
  localparam int unsigned IDX_W = $clog2(N);

  if (LEAK_SHIFT < 0 || LEAK_SHIFT >= PX_SIZE) begin : g_bad_shift
    $error("LEAK_SHIFT must lie in [0, PX_SIZE)");
  end

  typedef enum logic {CAPTURE, BACKPROP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       mask_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic [PX_SIZE-1:0] out_q;

  logic               fwd_fire, grad_fire, idx_last, fwd_pos;
  logic [PX_SIZE-1:0] gated;

  assign idx_last  = (idx_q == IDX_W'(N - 1));
  assign fwd_fire  = fwd_valid && fwd_ready;
  assign grad_fire = grad_in_valid && grad_in_ready;
  // Strictly positive two's-complement value: sign clear and non-zero.
  assign fwd_pos   = !fwd_px[PX_SIZE-1] && (fwd_px != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CAPTURE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      CAPTURE: begin
        if (fwd_fire) begin
          if (idx_last) begin
            state_d = BACKPROP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      BACKPROP: begin
        if (grad_fire) begin
          if (idx_last) begin
            state_d = CAPTURE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = CAPTURE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    fwd_ready      = (state_q == CAPTURE);
    mask_full      = (state_q == BACKPROP);
    grad_in_ready  = (state_q == BACKPROP) && (!out_valid_q || grad_out_ready);
    grad_out_valid = out_valid_q;
    grad_out       = out_q;
    frame_done     = out_valid_q && grad_out_ready && out_last_q;
  end

  always_comb begin
    gated = '0;
    if (mask_q[idx_q]) begin
      gated = grad_in;
    end else begin
`ifdef RELU_BP_LEAKY_EN
      gated = $unsigned($signed(grad_in) >>> LEAK_SHIFT);
`else
      gated = '0;
`endif
    end
  end

  // Output register holds its value whenever no new gradient is accepted, so a stalled beat stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_q       <= '0;
    end else begin
      if (fwd_fire) begin
        mask_q[idx_q] <= fwd_pos;
      end
      if (grad_fire) begin
        out_valid_q <= 1'b1;
        out_last_q  <= idx_last;
        out_q       <= gated;
      end else if (grad_out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
